// File: rtl/debounce_pkg.sv
// Shared state encodings and default parameters for the multi-channel debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } db_state_t;

  localparam int unsigned DEF_N           = 21;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_LP_N        = 26;

  // Debounced level is high while pressed or while a release is being qualified.
  function automatic logic level_of(input db_state_t st);
    return (st == ONE) || (st == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, 4-state FSM with stability down-counter,
// registered level/tick outputs and optional long-press detector (DEBOUNCE_LONGPRESS_EN).
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LP_N        = DEF_LP_N
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic long_tick
);

  localparam logic [N-1:0] Q_STEP = N'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state;
  db_state_t              next_state;
  logic [N-1:0]           q;
  logic [N-1:0]           q_next;
  logic [N-1:0]           q_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ZERO;
      q     <= '0;
    end else begin
      state <= next_state;
      q     <= q_next;
    end
  end

  always_comb begin
    next_state = state;
    q_next     = q;
    q_dec      = q - Q_STEP;
    case (state)
      ZERO: begin
        if (s) begin
          next_state = WAIT1;
          q_next     = '1;
        end
      end
      WAIT1: begin
        if (!s) begin
          next_state = ZERO;
        end else begin
          q_next = q_dec;
          if (q_dec == '0) next_state = ONE;
        end
      end
      ONE: begin
        if (!s) begin
          next_state = WAIT0;
          q_next     = '1;
        end
      end
      WAIT0: begin
        if (s) begin
          next_state = ONE;
        end else begin
          q_next = q_dec;
          if (q_dec == '0) next_state = ZERO;
        end
      end
      default: begin
        next_state = ZERO;
        q_next     = '0;
      end
    endcase
  end

  // Outputs load from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      db_level  <= level_of(next_state);
      rise_tick <= (state == WAIT1) && (next_state == ONE);
      fall_tick <= (state == WAIT0) && (next_state == ZERO);
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [LP_N-1:0] LP_STEP = LP_N'(1);

  logic [LP_N-1:0] lp;
  logic [LP_N-1:0] lp_next;

  always_comb begin
    lp_next = '0;
    if (state == ONE) begin
      lp_next = (lp == '1) ? lp : lp + LP_STEP;
    end
  end

  // Saturation keeps lp at all-ones, so the first-arrival test fires once per press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp        <= '0;
      long_tick <= 1'b0;
    end else begin
      lp        <= lp_next;
      long_tick <= (lp_next == '1) && (lp != '1);
    end
  end
`else
  assign long_tick = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// CH-channel switch debouncer; optional long-press pulses enabled by DEBOUNCE_LONGPRESS_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned N           = DEF_N,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LP_N        = DEF_LP_N
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] rise_tick,
  output logic [CH-1:0] fall_tick,
  output logic [CH-1:0] long_tick
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES),
      .LP_N        (LP_N)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (sw[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .long_tick (long_tick[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (CH=4, N=4, SYNC_STAGES=2, LP_N=6).
module tb_debounce_multi;

  localparam int CH    = 4;
  localparam int N     = 4;
  localparam int SS    = 2;
  localparam int LP_N  = 6;
  localparam int WIN   = 1 << N;
  localparam int LPMAX = (1 << LP_N) - 1;
  localparam int K_DB   = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_LONG = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] db_level, rise_tick, fall_tick, long_tick;

  int errors = 0;
  int checks = 0;

  debounce_multi #(
    .CH          (CH),
    .N           (N),
    .SYNC_STAGES (SS),
    .LP_N        (LP_N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw        (sw),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .long_tick (long_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a channel's level flips once the synchronised input has disagreed with it
  // for WIN consecutive samples; long press = LPMAX edges spent settled-high.
  logic [CH-1:0] m_p0, m_p1, m_lvl, m_rise, m_fall, m_long;
  int            m_cnt [CH];
  int            m_pc  [CH];

  always @(posedge clk or negedge reset_n) begin : model
    if (!reset_n) begin
      m_p0 <= '0; m_p1 <= '0; m_lvl <= '0;
      m_rise <= '0; m_fall <= '0; m_long <= '0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] <= 0;
        m_pc[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        automatic int   c       = m_cnt[i];
        automatic logic l       = m_lvl[i];
        automatic logic pressed = m_lvl[i] && (m_cnt[i] == 0);
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        m_long[i] <= 1'b0;
        if (m_p1[i] != l) begin
          c++;
          if (c == WIN) begin
            c = 0;
            l = ~l;
            if (l) m_rise[i] <= 1'b1;
            else   m_fall[i] <= 1'b1;
          end
        end else begin
          c = 0;
        end
        m_cnt[i] <= c;
        m_lvl[i] <= l;
        m_pc[i]  <= pressed ? m_pc[i] + 1 : 0;
`ifdef DEBOUNCE_LONGPRESS_EN
        if (pressed && (m_pc[i] + 1 == LPMAX)) m_long[i] <= 1'b1;
`endif
        m_p1[i] <= m_p0[i];
        m_p0[i] <= sw[i];
      end
    end
  end

  always @(negedge clk) begin
    check("outputs_vs_model", int'({db_level, rise_tick, fall_tick, long_tick}),
          int'({m_lvl, m_rise, m_fall, m_long}));
  end

  function automatic logic [CH-1:0] pick(input int kind);
    case (kind)
      K_DB:    return db_level;
      K_RISE:  return rise_tick;
      K_FALL:  return fall_tick;
      default: return long_tick;
    endcase
  endfunction

  // Edges until the selected bit goes high (observed 1 unit after each edge); -1 if never.
  task automatic measure(input int ch, input int kind, input int maxc, output int n);
    logic [CH-1:0] v;
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      v = pick(kind);
      if (v[ch]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int ticks;
    step(3);
    check("reset_outputs", int'({db_level, rise_tick, fall_tick, long_tick}), 0);
    reset_n = 1'b1;
    step(5);

    sw[0] = 1'b1;
    measure(0, K_DB, 40, n);
    check("ch0_rise_latency", n, 18);
    check("ch0_rise_tick", int'(rise_tick), 4'b0001);
    check("ch0_only_level", int'(db_level), 4'b0001);
    step(1);
    check("ch0_rise_single", int'(rise_tick), 0);

    ticks = 0;
    sw[1] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) sw[1] = 1'b0;
      step(1);
      if (db_level[1] || rise_tick[1] || fall_tick[1]) ticks++;
    end
    check("ch1_glitch_suppressed", ticks, 0);

    sw[1] = 1'b1;
    step(25);
    check("ch1_level_after_press", int'(db_level[1]), 1);
    sw[1] = 1'b0;
    measure(1, K_FALL, 40, n);
    check("ch1_fall_latency", n, 18);
    check("ch1_fall_tick", int'(fall_tick), 4'b0010);

    sw = '0;
    step(40);
    check("all_released", int'(db_level), 0);
    sw = 4'b1111;
    measure(0, K_RISE, 40, n);
    check("simul_rise_latency", n, 18);
    check("simul_rise_ticks", int'(rise_tick), 4'b1111);
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (rise_tick != '0) ticks++;
    end
    check("simul_rise_once", ticks, 0);

    sw = 4'b0001;
    step(40);
    check("pre_reset_level", int'(db_level), 4'b0001);
    sw = 4'b0101;
    step(8);
    #2 reset_n = 1'b0;
    #1 check("async_reset_clears", int'({db_level, rise_tick, fall_tick, long_tick}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    measure(2, K_DB, 40, n);
    check("ch2_fresh_window", n, 18);
    check("post_reset_rise", int'(rise_tick), 4'b0101);

    measure(0, K_LONG, 80, n);
`ifdef DEBOUNCE_LONGPRESS_EN
    check("long_latency", n, 63);
    check("long_ticks", int'(long_tick), 4'b0101);
`else
    check("long_absent", n, -1);
`endif
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (long_tick != '0) ticks++;
    end
    check("long_no_repeat", ticks, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CH, default 4, SHALL set the number of independent channels (1..32).
REQ-003 Parameter N, default 21, SHALL set the stability counter width; the window is 2^N cycles (40 ms at 50 MHz).
REQ-004 Parameter SYNC_STAGES, default 2, SHALL set the input synchroniser depth (2..4).
REQ-005 Parameter LP_N, default 26, SHALL set the long-press counter width (used only with DEBOUNCE_LONGPRESS_EN).
REQ-006 Port clk, input, 1 bit: the system clock.
REQ-007 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port sw, input, CH bits: raw asynchronous switch/button inputs.
REQ-009 Port db_level, output, CH bits: debounced level per channel.
REQ-010 Port rise_tick, output, CH bits: one-cycle active-high pulse on a debounced 0->1 transition.
REQ-011 Port fall_tick, output, CH bits: one-cycle active-high pulse on a debounced 1->0 transition.
REQ-012 Port long_tick, output, CH bits: one-cycle active-high pulse on a long press.

Function
REQ-013 Each sw bit SHALL pass through a SYNC_STAGES-flop synchroniser; the last stage is the synchronised input s.
REQ-014 Each channel SHALL run an independent FSM with states ZERO, WAIT1, ONE and WAIT0, plus an N-bit down-counter q.
REQ-015 Transitions from ZERO: s=1 -> WAIT1 with q loaded to all-ones; otherwise the FSM stays in ZERO.
REQ-016 Transitions from WAIT1: s=0 -> ZERO with no tick; s=1 -> q decrements, and when q-1==0 the FSM goes to ONE.
REQ-017 Transitions from ONE: s=0 -> WAIT0 with q loaded to all-ones.
REQ-018 Transitions from WAIT0: s=1 -> ONE with no tick; s=0 -> q decrements, and when q-1==0 the FSM goes to ZERO.
REQ-019 Any illegal state encoding SHALL return the FSM to ZERO on the next clock.
REQ-020 All outputs SHALL be registered: db_level=1 exactly in states ONE and WAIT0.
REQ-021 rise_tick SHALL be high only in the first cycle in ONE entered from WAIT1; fall_tick SHALL be high only in the first cycle in ZERO entered from WAIT0.
REQ-022 Latency: with s held stable, db_level SHALL change exactly 2^N cycles after s is first sampled at the new value, plus SYNC_STAGES cycles from raw sw.
REQ-023 A glitch shorter than 2^N cycles SHALL produce no level change and no tick.
REQ-024 Counter arithmetic SHALL be unsigned N-bit and SHALL never wrap, because it is reloaded on entering each WAIT state.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous per-channel ticks.

Reset
REQ-026 While reset_n=0: synchronisers=0, state=ZERO, q=0, and db_level, rise_tick, fall_tick and long_tick all =0.
REQ-027 Reset asserted mid-debounce SHALL discard the operation in progress with no tick on release.
REQ-028 Reset deassertion SHALL be synchronised by the system-level reset bridge, not inside this block.

Configuration
REQ-029 Macro DEBOUNCE_LONGPRESS_EN defined: each channel SHALL have an LP_N-bit up-counter.
REQ-030 With the macro defined, the up-counter SHALL be cleared whenever the state is not ONE and SHALL increment in ONE, saturating at all-ones.
REQ-031 With the macro defined, long_tick SHALL pulse for exactly one cycle when the counter first reaches all-ones, and only once per press.
REQ-032 Macro DEBOUNCE_LONGPRESS_EN undefined: no long-press logic SHALL be built and long_tick SHALL be tied to 0; the port list is unchanged.

Structure
REQ-033 Shared package debounce_pkg SHALL hold the 2-bit state encodings ZERO=00, WAIT0=01, ONE=10, WAIT1=11 and the default N, SYNC_STAGES and LP_N localparams.
REQ-034 Sub-module debounce_ch SHALL implement the synchroniser, FSM, counter and long-press logic of one channel.
REQ-035 debounce_multi SHALL instantiate CH copies of debounce_ch in a generate loop.

Verification (CH=4, N=4, SYNC_STAGES=2, LP_N=6)
REQ-036 sw[0] 0->1 held stable -> db_level[0] rises 18 cycles after the raw edge, with rise_tick[0] high for 1 cycle in that cycle and other channels unchanged.
REQ-037 sw[1] high for 10 cycles then low -> db_level[1] stays 0 and no ticks occur; a subsequent 1->0 release after debounce -> fall_tick[1] pulses once, 18 cycles after the edge.
REQ-038 sw[3:0]=4'b1111 applied in one cycle -> rise_tick=4'b1111 in the same cycle, once.
REQ-039 reset_n pulsed low while channel 2 is in WAIT1 -> all outputs 0 immediately, with no tick after release and sw[2] still high until a fresh 16-cycle window elapses.
REQ-040 With DEBOUNCE_LONGPRESS_EN defined and sw[0] held high: long_tick[0] pulses once, 63 cycles after rise_tick[0], and never repeats during the hold; without the macro, long_tick stays 0.
